// File: rtl/relprime_pkg.sv
// Shared definitions for the relPrime core and its program-memory loader.
// Pure constants and types; no logic.
// Word width is fixed by the 16-bit ISA.
package relprime_pkg;

    localparam int WORD_W = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR_A = 3'd1;
    localparam logic [2:0] ST_HDR_L = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CHK = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
    localparam logic [2:0] ST_ERR = 3'd6;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        HDR_A = ST_HDR_A,
        HDR_L = ST_HDR_L,
        DATA  = ST_DATA,
        CHK   = ST_CHK,
        DONE  = ST_DONE,
        ERR   = ST_ERR
    } state_t;

endpackage

// File: rtl/prog_mem_loader_if.sv
// Stream-in, memory-write and status signals of the program loader.
// master = stimulus/board side, slave = loader.
// Backpressure: in_valid/in_ready handshake on the stream side only.
interface prog_mem_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Loads BASE/LEN/data/CSUM word stream into program memory, holding the core in reset.
// Latency: memory write issued one cycle after each accepted data word.
// Backpressure: in_ready only in header/data/checksum states; in_valid low stalls with no effect.
module prog_mem_loader
    import relprime_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = WORD_W
) (
    input  logic               CLK,
    input  logic               RST,
    prog_mem_loader_if.slave   bus
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [DATA_W-1:0] cnt, cnt_nx;
    logic [DATA_W-1:0] sum, sum_nx;
    logic              hs;
    logic              wr_nx;

    assign hs = bus.in_valid & bus.in_ready;

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        cnt_nx   = cnt;
        sum_nx   = sum;
        wr_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nx = HDR_A;
            end
            HDR_A: begin
                if (hs) begin
                    addr_nx  = bus.in_data[ADDR_W-1:0];
                    state_nx = HDR_L;
                end
            end
            HDR_L: begin
                if (hs) begin
                    cnt_nx   = bus.in_data;
                    sum_nx   = '0;
                    state_nx = (bus.in_data == '0) ? CHK : DATA;
                end
            end
            DATA: begin
                if (hs) begin
                    wr_nx   = 1'b1;
                    addr_nx = addr + ADDR_W'(1);
                    sum_nx  = sum + bus.in_data;
                    cnt_nx  = cnt - DATA_W'(1);
                    if (cnt == DATA_W'(1)) state_nx = CHK;
                end
            end
            CHK: begin
                if (hs) state_nx = (bus.in_data == sum) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (bus.start) state_nx = HDR_A;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            addr  <= '0;
            cnt   <= '0;
            sum   <= '0;
        end else begin
            state <= state_nx;
            addr  <= addr_nx;
            cnt   <= cnt_nx;
            sum   <= sum_nx;
        end
    end

    // Outputs decode the next state so cpu_hold drops on the same edge done rises.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_hold  <= 1'b1;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
        end else begin
            bus.in_ready <= (state_nx == HDR_A) || (state_nx == HDR_L) ||
                            (state_nx == DATA)  || (state_nx == CHK);
            bus.mem_we   <= wr_nx;
            if (wr_nx) begin
                bus.mem_addr  <= addr;
                bus.mem_wdata <= bus.in_data;
            end
            bus.cpu_hold <= (state_nx != DONE);
            bus.done     <= (state_nx == DONE);
            bus.error    <= (state_nx == ERR);
        end
    end

endmodule
